// File: rtl/alu_pkg.sv
// Shared definitions for the ALU_8bit datapath, its command issuer and benches.
//   OP_*        : opcode encodings understood by ALU_8bit
//   state_e     : issuer FSM state encoding
//   cmd_t       : packed {opcode, B, A} command word as stored in the FIFO
//   is_legal_op : true for the five opcodes ALU_8bit implements
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;

  localparam int CMD_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, ALU-side and response signals of alu_cmd_issuer.
//   master : the issuer (drives cmd_ready, alu_*, rsp_*, busy, ops_done)
//   slave  : the environment (command source, ALU_8bit and response consumer)
// Optional feature macro: ALU_ILLEGAL_OP_CHECK_EN adds rsp_error.
interface alu_cmd_issuer_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_opcode;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_opcode;
  logic [7:0]       alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic [2:0]       rsp_opcode;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             rsp_error;
`endif
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  modport master (
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    output rsp_error,
`endif
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode,
    input  alu_result, alu_zero, alu_overflow, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_opcode,
    output busy, ops_done
  );

  modport slave (
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    input  rsp_error,
`endif
    output cmd_valid, cmd_a, cmd_b, cmd_opcode,
    output alu_result, alu_zero, alu_overflow, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_opcode,
    input  busy, ops_done
  );

endinterface

// File: rtl/alu_8bit.sv
// ALU_8bit: combinational 8-bit ALU driven by alu_cmd_issuer.
//   a, b          : operands
//   opcode        : OP_ADD/OP_SUB/OP_AND/OP_OR/OP_XOR, anything else yields 0
//   result        : operation result
//   zero_flag     : result == 0
//   overflow_flag : signed (two's complement) overflow of ADD/SUB
module ALU_8bit
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opcode,
  output logic [7:0] result,
  output logic       zero_flag,
  output logic       overflow_flag
);

  // Operation select and flag generation
  always_comb begin
    result        = 8'h00;
    overflow_flag = 1'b0;
    case (opcode)
      OP_ADD: begin
        result        = a + b;
        overflow_flag = (a[7] == b[7]) && (result[7] != a[7]);
      end
      OP_SUB: begin
        result        = a - b;
        overflow_flag = (a[7] != b[7]) && (result[7] != a[7]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = 8'h00;
    endcase
    zero_flag = (result == 8'h00);
  end

endmodule

// File: rtl/alu_cmd_issuer_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding {opcode,B,A} commands.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head
//   full, empty   : derived from a separate occupancy count so the wrapping
//                   pointers never need an extra lap bit
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives them into ALU_8bit with registered
// operands, waits SETTLE_CYCLES, captures the ALU outputs and returns one
// response per command.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_cmd_issuer_if.master (command, ALU and response signals)
// Optional feature macro: ALU_ILLEGAL_OP_CHECK_EN -- opcodes outside the ALU's
// set skip the ALU and answer immediately with rsp_error=1 and zeroed flags.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_cmd_issuer_if.master bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  cmd_t       push_data_s, pop_data_s;
  logic       push_s, pop_s, full_s, empty_s;

  state_e     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_opcode_q, alu_opcode_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_overflow_q, rsp_overflow_d;
  logic [2:0] rsp_opcode_q, rsp_opcode_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic       rsp_error_q, rsp_error_d;
`endif
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  assign push_data_s = cmd_t'({bus.cmd_opcode, bus.cmd_b, bus.cmd_a});
  assign push_s      = bus.cmd_valid && !full_s;
  // Only IDLE consumes commands, so a pop never coincides with a handshake.
  assign pop_s       = (state_q == ST_IDLE) && !empty_s;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (pop_data_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // FSM next-state and datapath register updates
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_opcode_d   = alu_opcode_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_opcode_d   = rsp_opcode_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    rsp_error_d    = rsp_error_q;
`endif
    ops_done_d     = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          if (!is_legal_op(pop_data_s.opcode)) begin
            // alu_* untouched: the ALU never sees an illegal opcode.
            rsp_valid_d    = 1'b1;
            rsp_result_d   = 8'h00;
            rsp_zero_d     = 1'b0;
            rsp_overflow_d = 1'b0;
            rsp_opcode_d   = pop_data_s.opcode;
            rsp_error_d    = 1'b1;
            state_d        = ST_RESP;
          end else begin
            alu_a_d      = pop_data_s.a;
            alu_b_d      = pop_data_s.b;
            alu_opcode_d = pop_data_s.opcode;
            settle_d     = {SW{1'b0}};
            state_d      = ST_WAIT;
          end
`else
          alu_a_d      = pop_data_s.a;
          alu_b_d      = pop_data_s.b;
          alu_opcode_d = pop_data_s.opcode;
          settle_d     = {SW{1'b0}};
          state_d      = ST_WAIT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          rsp_valid_d    = 1'b1;
          rsp_result_d   = bus.alu_result;
          rsp_zero_d     = bus.alu_zero;
          rsp_overflow_d = bus.alu_overflow;
          rsp_opcode_d   = alu_opcode_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          rsp_error_d    = 1'b0;
`endif
          state_d        = ST_RESP;
        end else begin
          settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
          state_d  = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      settle_q       <= {SW{1'b0}};
      alu_a_q        <= 8'h00;
      alu_b_q        <= 8'h00;
      alu_opcode_q   <= 3'b000;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= 8'h00;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_opcode_q   <= 3'b000;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      rsp_error_q    <= 1'b0;
`endif
      ops_done_q     <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_opcode_q   <= alu_opcode_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_opcode_q   <= rsp_opcode_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      rsp_error_q    <= rsp_error_d;
`endif
      ops_done_q     <= ops_done_d;
    end
  end

  assign bus.cmd_ready    = !full_s;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_opcode   = rsp_opcode_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign bus.rsp_error    = rsp_error_q;
`endif
  assign bus.busy         = (state_q != ST_IDLE) || !empty_s;
  assign bus.ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer driving a real ALU_8bit, SETTLE_CYCLES=1.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_cmd_issuer_if #(.CNT_W(16)) bus ();

  alu_cmd_issuer #(.DEPTH(4), .SETTLE_CYCLES(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ALU_8bit u_alu (
    .a             (bus.alu_a),
    .b             (bus.alu_b),
    .opcode        (bus.alu_opcode),
    .result        (bus.alu_result),
    .zero_flag     (bus.alu_zero),
    .overflow_flag (bus.alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst table: OR, XOR, ADD, SUB (zero result), AND
  logic [7:0] t_a   [5] = '{8'hAA, 8'hAA, 8'h01, 8'h05, 8'hF0};
  logic [7:0] t_b   [5] = '{8'h55, 8'h55, 8'h02, 8'h05, 8'h3C};
  logic [2:0] t_op  [5] = '{3'b011, 3'b101, 3'b000, 3'b001, 3'b010};
  logic [7:0] t_res [5] = '{8'hFF, 8'hFF, 8'h03, 8'h00, 8'h30};
  logic       t_z   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_opcode = op;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.rsp_valid), 64'd1);
  endtask

  // Full operation with rsp_ready=1: check result and flags, then consume.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] res, input logic z,
                        input logic o);
    push(a, b, op);
    wait_rsp({tag, "_valid"});
    chk({tag, "_res"}, 64'(bus.rsp_result), 64'(res));
    chk({tag, "_flags"}, 64'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_opcode}), 64'({z, o, op}));
    tick();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = 8'h00;
    bus.cmd_b      = 8'h00;
    bus.cmd_opcode = 3'b000;
    bus.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ops_done", 64'(bus.ops_done), 64'd0);
    chk("rst_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_opcode}), 64'd0);
    chk("rst_rsp_fields", 64'({bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_opcode}), 64'd0);
    rst = 1'b0;
    tick();

    // 1: ADD CC+33, latency: valid in the third cycle after the push cycle
    push(8'hCC, 8'h33, OP_ADD);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_valid_c1", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("t1_valid_c2", 64'(bus.rsp_valid), 64'd0);
    chk("t1_alu_load", 64'({bus.alu_a, bus.alu_b, bus.alu_opcode}), 64'({8'hCC, 8'h33, 3'b000}));
    tick();
    chk("t1_valid_c3", 64'(bus.rsp_valid), 64'd1);
    chk("t1_res", 64'(bus.rsp_result), 64'hFF);
    chk("t1_flags", 64'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_opcode}), 64'({1'b0, 1'b0, 3'b000}));
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_handshake", 64'(bus.rsp_valid), 64'd0);
    chk("t1_ops_done", 64'(bus.ops_done), 64'd1);

    // 2: SUB, signed-overflow ADD, AND giving zero
    run_op("t2_sub", 8'hCC, 8'h33, OP_SUB, 8'h99, 1'b0, 1'b0);
    run_op("t2_add_ovf", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b1);
    run_op("t2_and_zero", 8'hCC, 8'h33, OP_AND, 8'h00, 1'b1, 1'b0);
    chk("t2_ops_done", 64'(bus.ops_done), 64'd4);

    // 3: five back-to-back pushes with rsp_ready=0. The first is popped while
    // the second is pushed, so the FIFO fills only on the fifth push.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(t_a[i], t_b[i], t_op[i]);
      if (i == 3) chk("t3_ready_after4", 64'(bus.cmd_ready), 64'd1);
    end
    chk("t3_full", 64'(bus.cmd_ready), 64'd0);
    tick();
    tick();
    chk("t3_still_full", 64'(bus.cmd_ready), 64'd0);
    chk("t3_head_held", 64'({bus.rsp_valid, bus.rsp_result}), 64'({1'b1, 8'hFF}));
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("t3_valid");
      chk("t3_order_res", 64'(bus.rsp_result), 64'(t_res[i]));
      chk("t3_order_op", 64'({bus.rsp_zero, bus.rsp_opcode}), 64'({t_z[i], t_op[i]}));
      tick();
    end
    chk("t3_ops_done", 64'(bus.ops_done), 64'd9);

    // 4: response and operands stable under backpressure
    bus.rsp_ready = 1'b0;
    push(8'h10, 8'h20, OP_ADD);
    wait_rsp("t4_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold",
          64'({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_opcode,
               bus.alu_a, bus.alu_b, bus.alu_opcode}),
          64'({1'b1, 8'h30, 1'b0, 1'b0, 3'b000, 8'h10, 8'h20, 3'b000}));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t4_ops_done", 64'(bus.ops_done), 64'd10);
    chk("t4_released", 64'(bus.rsp_valid), 64'd0);

    // 5: reset while in WAIT with three commands queued
    bus.rsp_ready = 1'b0;
    push(8'h11, 8'h22, OP_ADD);
    push(8'h33, 8'h44, OP_ADD);
    push(8'h55, 8'h66, OP_ADD);
    push(8'h77, 8'h88, OP_ADD);
    push(8'h99, 8'hAA, OP_ADD);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    chk("t5_in_wait", 64'({bus.rsp_valid, bus.busy, bus.alu_a}), 64'({1'b0, 1'b1, 8'h33}));
    chk("t5_ops_pre", 64'(bus.ops_done), 64'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("t5_ops_done", 64'(bus.ops_done), 64'd0);
    tick();
    chk("t5_drained", 64'({bus.busy, bus.rsp_valid}), 64'd0);
    bus.rsp_ready = 1'b1;
    run_op("t5_after", 8'h01, 8'h01, OP_ADD, 8'h02, 1'b0, 1'b0);
    chk("t5_ops_after", 64'(bus.ops_done), 64'd1);

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    // 6: illegal opcode answers straight from IDLE, ALU inputs untouched
    push(8'h55, 8'h66, 3'b110);
    tick();
    chk("t6_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t6_rsp", 64'({bus.rsp_error, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_opcode}),
        64'({1'b1, 8'h00, 1'b0, 1'b0, 3'b110}));
    chk("t6_alu_kept", 64'({bus.alu_a, bus.alu_b, bus.alu_opcode}), 64'({8'h01, 8'h01, 3'b000}));
    tick();
    push(8'h0F, 8'hF0, OP_XOR);
    wait_rsp("t6_xor_valid");
    chk("t6_xor", 64'({bus.rsp_error, bus.rsp_result, bus.rsp_opcode}), 64'({1'b0, 8'hFF, 3'b101}));
    tick();
    chk("t6_ops_done", 64'(bus.ops_done), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
